// File: rtl/mem_resp_pkg.sv
// Shared encodings for the memory responder: access sizes, FSM states and the alignment rule.
package mem_resp_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [2:0] {
    IDLE,
    RD,
    RDW,
    WR,
    RSP
  } state_t;

  // A half needs an even address, a word needs a 4-byte aligned address.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
    logic mis;
    mis = 1'b0;
    if (size == SZ_HALF) mis = off[0];
    else if (size == SZ_WORD) mis = (off != 2'b00);
    return mis;
  endfunction

endpackage

// File: rtl/mem_responder_lane_align.sv
// Combinational lane handling: extracts and extends load data, and merges sub-word store data
// into a word that has been read back from the SRAM.
module lane_align
  import mem_resp_pkg::*;
(
  input  logic [31:0] word,
  input  logic [31:0] new_data,
  input  logic [1:0]  offset,
  input  logic [1:0]  size,
  input  logic        is_unsigned,
  output logic [31:0] extract_c,
  output logic [31:0] merged_c
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  always_comb begin
    byte_lane = word[{offset, 3'b000} +: 8];
    half_lane = word[{offset[1], 4'b0000} +: 16];
    extract_c = word;
    merged_c  = new_data;
    case (size)
      SZ_BYTE: begin
        extract_c = {{24{byte_lane[7] & ~is_unsigned}}, byte_lane};
        merged_c  = word;
        merged_c[{offset, 3'b000} +: 8] = new_data[7:0];
      end
      SZ_HALF: begin
        extract_c = {{16{half_lane[15] & ~is_unsigned}}, half_lane};
        merged_c  = word;
        merged_c[{offset[1], 4'b0000} +: 16] = new_data[15:0];
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_responder.sv
// Load/store responder in front of a word-wide SRAM without byte enables; sub-word stores
// are done as read-modify-write. Optional MISALIGN_CHECK_EN rejects misaligned half/word accesses.
module mem_responder
  import mem_resp_pkg::*;
#(
  parameter int unsigned ADDR_W     = 10,
  parameter int unsigned REGION_BIT = 28
) (
  input  logic              clockCPU,
  input  logic              reset,
  input  logic              reqValid,
  output logic              reqReady,
  input  logic              reqWrite,
  input  logic [1:0]        reqSize,
  input  logic              reqUnsigned,
  input  logic [31:0]       reqAddr,
  input  logic [31:0]       reqWData,
  output logic              rspValid,
  output logic [31:0]       rspRData,
  output logic              rspErr,
  output logic              memSel,
  output logic [ADDR_W-1:0] memAddr,
  output logic [31:0]       memWData,
  output logic              memWren,
  input  logic [31:0]       memRData
);

  state_t state_q, state_d;

  logic [1:0]  off_q, off_d;
  logic [1:0]  size_q, size_d;
  logic        uns_q, uns_d;
  logic        write_q, write_d;
  logic [31:0] wdata_q, wdata_d;

  logic              ready_d, rsp_valid_d, rsp_err_d, mem_sel_d, mem_wren_d;
  logic [31:0]       rsp_rdata_d, mem_wdata_d;
  logic [ADDR_W-1:0] mem_addr_d;

  logic [1:0]  size_n;
  logic        misaligned;
  logic [31:0] extract_c, merged_c;
  logic        unused_addr;

  // Illegal size 11 behaves as a word access.
  assign size_n      = (reqSize == 2'b11) ? SZ_WORD : reqSize;
  assign unused_addr = ^reqAddr;

`ifdef MISALIGN_CHECK_EN
  assign misaligned = is_misaligned(size_n, reqAddr[1:0]);
`else
  assign misaligned = 1'b0;
`endif

  lane_align u_lane_align (
    .word       (memRData),
    .new_data   (wdata_q),
    .offset     (off_q),
    .size       (size_q),
    .is_unsigned(uns_q),
    .extract_c  (extract_c),
    .merged_c   (merged_c)
  );

  always_ff @(posedge clockCPU or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      off_q    <= 2'b00;
      size_q   <= SZ_WORD;
      uns_q    <= 1'b0;
      write_q  <= 1'b0;
      wdata_q  <= 32'd0;
      reqReady <= 1'b1;
      rspValid <= 1'b0;
      rspRData <= 32'd0;
      rspErr   <= 1'b0;
      memSel   <= 1'b0;
      memAddr  <= '0;
      memWData <= 32'd0;
      memWren  <= 1'b0;
    end else begin
      state_q  <= state_d;
      off_q    <= off_d;
      size_q   <= size_d;
      uns_q    <= uns_d;
      write_q  <= write_d;
      wdata_q  <= wdata_d;
      reqReady <= ready_d;
      rspValid <= rsp_valid_d;
      rspRData <= rsp_rdata_d;
      rspErr   <= rsp_err_d;
      memSel   <= mem_sel_d;
      memAddr  <= mem_addr_d;
      memWData <= mem_wdata_d;
      memWren  <= mem_wren_d;
    end
  end

  // Next state plus the next value of every registered output.
  always_comb begin
    state_d     = state_q;
    off_d       = off_q;
    size_d      = size_q;
    uns_d       = uns_q;
    write_d     = write_q;
    wdata_d     = wdata_q;
    rsp_rdata_d = rspRData;
    rsp_err_d   = 1'b0;
    mem_sel_d   = memSel;
    mem_addr_d  = memAddr;
    mem_wdata_d = memWData;
    mem_wren_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (reqValid && reqReady) begin
          off_d      = reqAddr[1:0];
          size_d     = size_n;
          uns_d      = reqUnsigned;
          write_d    = reqWrite;
          wdata_d    = reqWData;
          mem_sel_d  = reqAddr[REGION_BIT];
          mem_addr_d = reqAddr[ADDR_W+1:2];
          if (misaligned) begin
            state_d     = RSP;
            rsp_err_d   = 1'b1;
            rsp_rdata_d = 32'd0;
          end else if (reqWrite && (size_n == SZ_WORD)) begin
            state_d     = WR;
            mem_wren_d  = 1'b1;
            mem_wdata_d = reqWData;
          end else begin
            state_d = RD;
          end
        end
      end
      RD: state_d = RDW;
      RDW: begin
        if (write_q) begin
          state_d     = WR;
          mem_wren_d  = 1'b1;
          mem_wdata_d = merged_c;
        end else begin
          state_d     = RSP;
          rsp_rdata_d = extract_c;
        end
      end
      WR: begin
        state_d     = RSP;
        rsp_rdata_d = 32'd0;
      end
      RSP: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    ready_d     = (state_d == IDLE);
    rsp_valid_d = (state_d == RSP);
  end

endmodule
